// File: rtl/output_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_vc_arbiter
// Description : Per-output-port scheduler. Arbitrates 4 requesters onto one
//               output buffer, using two virtual channels (even/odd) selected
//               by the polarity bit. Each VC keeps its own round-robin pointer
//               and a FREE/RESERVED/OCCUPIED occupancy tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module output_vc_arbiter #(
    parameter int TIMEOUT = 8,
    parameter int TMR_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       polarity,
    input  logic [3:0] req_even,
    input  logic [3:0] req_odd,
    input  logic       buf_full_even,
    input  logic       buf_full_odd,
    output logic [3:0] grant,
    output logic       grant_vc,
    output logic       grant_valid,
    output logic [1:0] vc_busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_RESERVED = 2'd1,
        ST_OCCUPIED = 2'd2
    } vc_state_t;

    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] C_TMR_ONE  = TMR_W'(1);

    // Per-VC state, indexed by VC number (0 = even, 1 = odd)
    logic [1:0]       ptr_q   [2];
    logic [1:0]       ptr_d   [2];
    vc_state_t        state_q [2];
    vc_state_t        state_d [2];
    logic [TMR_W-1:0] timer_q [2];
    logic [TMR_W-1:0] timer_d [2];

    logic [3:0] grant_q,       grant_d;
    logic       grant_vc_q,    grant_vc_d;
    logic       grant_valid_q, grant_valid_d;
    logic [1:0] vc_busy_q,     vc_busy_d;
    logic       timeout_err_q, timeout_err_d;

    // Arbitration working signals for the VC selected by polarity
    logic [1:0] w_buf_full;
    logic [3:0] w_req;
    logic       w_eligible;
    logic [1:0] w_pick;
    logic       w_found;
    logic [1:0] w_idx;

    assign w_buf_full = {buf_full_odd, buf_full_even};

    // Round-robin pick for the VC whose turn it is this cycle
    always_comb begin
        w_req      = polarity ? req_odd : req_even;
        w_eligible = (w_req != 4'b0000) &&
                     (state_q[polarity] == ST_FREE) &&
                     !w_buf_full[polarity];
        w_found    = 1'b0;
        w_pick     = 2'd0;
        w_idx      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_idx = ptr_q[polarity] + 2'(i);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Grant outputs; grant_vc keeps the VC of the last real grant
    always_comb begin
        grant_d       = 4'b0000;
        grant_valid_d = 1'b0;
        grant_vc_d    = grant_vc_q;
        if (w_eligible) begin
            grant_d         = 4'b0000;
            grant_d[w_pick] = 1'b1;
            grant_valid_d   = 1'b1;
            grant_vc_d      = polarity;
        end
    end

    // Occupancy tracking for both VCs, independent of polarity
    always_comb begin
        timeout_err_d = timeout_err_q;
        for (int v = 0; v < 2; v++) begin
            ptr_d[v]   = ptr_q[v];
            state_d[v] = state_q[v];
            timer_d[v] = timer_q[v];
            case (state_q[v])
                ST_FREE: begin
                    if (w_eligible && (polarity == 1'(v))) begin
                        state_d[v] = ST_RESERVED;
                        timer_d[v] = '0;
                        ptr_d[v]   = w_pick + 2'd1;
                    end else if (w_buf_full[v]) begin
                        // Buffer filled without a grant of ours; track it anyway
                        state_d[v] = ST_OCCUPIED;
                    end
                end
                ST_RESERVED: begin
                    if (w_buf_full[v]) begin
                        state_d[v] = ST_OCCUPIED;
                        timer_d[v] = '0;
                    end else if (timer_q[v] == C_TMR_LAST) begin
                        state_d[v]    = ST_FREE;
                        timer_d[v]    = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        timer_d[v] = timer_q[v] + C_TMR_ONE;
                    end
                end
                ST_OCCUPIED: begin
                    if (!w_buf_full[v]) begin
                        state_d[v] = ST_FREE;
                    end
                end
                default: begin
                    state_d[v] = ST_FREE;
                    timer_d[v] = '0;
                end
            endcase
            vc_busy_d[v] = (state_d[v] != ST_FREE);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q       <= 4'b0000;
            grant_vc_q    <= 1'b0;
            grant_valid_q <= 1'b0;
            vc_busy_q     <= 2'b00;
            timeout_err_q <= 1'b0;
            for (int v = 0; v < 2; v++) begin
                ptr_q[v]   <= 2'd0;
                state_q[v] <= ST_FREE;
                timer_q[v] <= '0;
            end
        end else begin
            grant_q       <= grant_d;
            grant_vc_q    <= grant_vc_d;
            grant_valid_q <= grant_valid_d;
            vc_busy_q     <= vc_busy_d;
            timeout_err_q <= timeout_err_d;
            for (int v = 0; v < 2; v++) begin
                ptr_q[v]   <= ptr_d[v];
                state_q[v] <= state_d[v];
                timer_q[v] <= timer_d[v];
            end
        end
    end

    assign grant       = grant_q;
    assign grant_vc    = grant_vc_q;
    assign grant_valid = grant_valid_q;
    assign vc_busy     = vc_busy_q;
    assign timeout_err = timeout_err_q;

    // The buffer controller relies on at most one requester being granted
    a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant_q));

endmodule
`default_nettype wire
